// File: rtl/rr_arb4_sel_pkg.sv
// Shared constants for the 4-way round-robin select arbiter.
// The mux stage reuses SRC_W/NSRC for its select width.
package rr_arb4_sel_pkg;

  localparam int SRC_W = 2;
  localparam int NSRC  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [NSRC-1:0] dec(
    input logic [SRC_W-1:0] s
  );
    logic [NSRC-1:0] r;
    r = '0;
    r[s] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/rr_arb4_sel_pick4.sv
// Rotating first-set-bit picker, NAND gate netlist.
// Searches req & ~mask from ptr upward, wrapping 3 to 0.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  input  logic [3:0] mask,
  output logic [1:0] idx,
  output logic       any
);

  wire [1:0] np;
  wire [3:0] npd;
  wire [3:0] pd;
  wire [3:0] nmask;
  wire [3:0] nm;
  wire [3:0] m;
  wire [3:1] win;
  wire [3:1] nwin;

  nand u_np0 (np[0], ptr[0], ptr[0]);
  nand u_np1 (np[1], ptr[1], ptr[1]);

  nand u_npd0 (npd[0], np[1], np[0]);
  nand u_npd1 (npd[1], np[1], ptr[0]);
  nand u_npd2 (npd[2], ptr[1], np[0]);
  nand u_npd3 (npd[3], ptr[1], ptr[0]);

  for (genvar k = 0; k < 4; k++) begin : g_bit
    nand u_pd (pd[k], npd[k], npd[k]);
    nand u_nk (nmask[k], mask[k], mask[k]);
    nand u_nm (nm[k], req[k], nmask[k]);
    nand u_m  (m[k], nm[k], nm[k]);
  end

  // Source 0 never drives idx, so only 1..3 get win terms.
  for (genvar k = 1; k < 4; k++) begin : g_win
    wire [3:0] nt;
    for (genvar p = 0; p < 4; p++) begin : g_ptr
      localparam int DK = (k - p + 4) % 4;
      wire [3:0] blk;
      for (genvar j = 0; j < 4; j++) begin : g_blk
        localparam int DJ = (j - p + 4) % 4;
        if (j == k) begin : g_self
          assign blk[j] = m[k];
        end else if (DJ < DK) begin : g_prio
          assign blk[j] = nm[j];
        end else begin : g_none
          assign blk[j] = 1'b1;
        end
      end
      nand u_t (nt[p], pd[p],
                blk[0], blk[1], blk[2], blk[3]);
    end
    nand u_w  (win[k], nt[0], nt[1], nt[2], nt[3]);
    nand u_nw (nwin[k], win[k], win[k]);
  end

  nand u_i0 (idx[0], nwin[1], nwin[3]);
  nand u_i1 (idx[1], nwin[2], nwin[3]);
  nand u_any (any, nm[0], nm[1], nm[2], nm[3]);

endmodule

// File: rtl/rr_arb4_sel.sv
// Round-robin arbiter driving the 4:1 mux select.
// Registered sel/gnt/vld/tmo with hold timeout.
module rr_arb4_sel
  import rr_arb4_sel_pkg::*;
#(
  parameter int MAX_HOLD = 15,
  parameter int HOLD_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NSRC-1:0]  req,
  input  logic             ack,
  output logic [SRC_W-1:0] sel,
  output logic [NSRC-1:0]  gnt,
  output logic             vld,
  output logic             tmo
);

  state_e            state_q, state_d;
  logic [SRC_W-1:0]  sel_q, sel_d;
  logic [SRC_W-1:0]  ptr_q, ptr_d;
  logic [NSRC-1:0]   gnt_q, gnt_d;
  logic              vld_q, vld_d;
  logic              tmo_q, tmo_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;

  logic              in_grant;
  logic [SRC_W-1:0]  pk_ptr;
  logic [NSRC-1:0]   pk_mask;
  logic [SRC_W-1:0]  pk_idx;
  logic              pk_any;
  logic              done;
  logic              drop;
  logic              expire;

  assign in_grant = (state_q == GRANT);
  assign pk_ptr   = in_grant ? sel_q + 2'd1 : ptr_q;
  assign pk_mask  = in_grant ? dec(sel_q) : '0;
  assign done     = ack;
  assign drop     = !req[sel_q];
  assign expire   = (cnt_q == HOLD_W'(MAX_HOLD - 1));

  rr_pick4 u_pick (
    .req  (req),
    .ptr  (pk_ptr),
    .mask (pk_mask),
    .idx  (pk_idx),
    .any  (pk_any)
  );

  // Next-state: arbitrate from IDLE, exit/re-arbitrate in GRANT.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pk_any) begin
          state_d = GRANT;
          sel_d   = pk_idx;
          gnt_d   = dec(pk_idx);
          vld_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (done || drop || expire) begin
          tmo_d = !done && !drop;
          ptr_d = sel_q + 2'd1;
          cnt_d = '0;
          if (pk_any) begin
            sel_d = pk_idx;
            gnt_d = dec(pk_idx);
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            vld_d   = 1'b0;
          end
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel = sel_q;
  assign gnt = gnt_q;
  assign vld = vld_q;
  assign tmo = tmo_q;

endmodule
